vga_frame_monitor: RTL and testbench

- Receive-side checker for the VGA pixel stream (r/g/b, hs, vs, blank_n) that the video output block generates.
- Measures horizontal and vertical timing, counts frames, and forms a per-frame pixel checksum.
- Declares lock once timing is stable; results feed the test register space for hardware self-check.
- Runs in the pixel clock domain; pixel_en qualifies each pixel slot.

---
 rtl/vga_mon_pkg.sv | 25 ++
 rtl/vga_sync_edge.sv | 29 ++
 rtl/vga_frame_monitor.sv | 253 +++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared types for the VGA frame monitor: FSM states, timing record, sync polarity helper.
// Declarations only; no latency, no flow control.
package vga_mon_pkg;

   localparam int CNT_W_MAX = 16;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   // Counter widths up to CNT_W_MAX; narrower counters are zero-extended into it.
   typedef struct packed {
      logic [CNT_W_MAX-1:0] h_total;
      logic [CNT_W_MAX-1:0] h_active;
      logic [CNT_W_MAX-1:0] v_total;
      logic [CNT_W_MAX-1:0] v_active;
   } timing_t;

   function automatic logic sync_asserted(input logic sync_raw, input logic active_low);
      return active_low ? ~sync_raw : sync_raw;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Polarity-normalising assertion-edge detector; only pixel_en slots are sampled.
// Edge is combinational in the qualifying slot; no backpressure (sink always accepts).
module vga_sync_edge
   import vga_mon_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pixel_en,
   input  logic sync_raw,
   output logic sync_edge
);

   logic sync_act;
   logic prev_act;

   assign sync_act  = sync_asserted(sync_raw, ACTIVE_LOW);
   assign sync_edge = pixel_en & sync_act & ~prev_act;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_act <= 1'b0;
      end else if (pixel_en) begin
         prev_act <= sync_act;
      end
   end

endmodule

// File: rtl/vga_frame_monitor.sv
// Measures VGA line/frame timing and a per-frame pixel checksum, and tracks timing lock.
// Results and frame_done appear 1 clk after the qualifying vs edge; no backpressure.
module vga_frame_monitor
   import vga_mon_pkg::*;
#(
   parameter int CNT_W           = 12,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2,
   parameter int TIMEOUT_CYC     = 2000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixel_en,
   input  logic [7:0]       vga_r,
   input  logic [7:0]       vga_g,
   input  logic [7:0]       vga_b,
   input  logic             vga_hs,
   input  logic             vga_vs,
   input  logic             vga_blank_n,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic [31:0]      frame_sum,
   output logic [15:0]      frame_count,
   output logic             locked,
   output logic             frame_done,
   output logic             lost
);

   localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
   localparam logic [3:0]        LOCK_N    = 4'(LOCK_FRAMES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic hs_edge;
   logic vs_edge;

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs_edge (
      .clk       (clk),
      .reset     (reset),
      .pixel_en  (pixel_en),
      .sync_raw  (vga_hs),
      .sync_edge (hs_edge)
   );

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs_edge (
      .clk       (clk),
      .reset     (reset),
      .pixel_en  (pixel_en),
      .sync_raw  (vga_vs),
      .sync_edge (vs_edge)
   );

   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] line_act;
   logic [CNT_W-1:0] line_len;
   logic [CNT_W-1:0] h_act_acc;
   logic [CNT_W-1:0] vcnt;
   logic [CNT_W-1:0] vact;
   logic [31:0]      sum_acc;
   logic [31:0]      pix_val;
   logic [CNT_W-1:0] act_one;

   assign pix_val = vga_blank_n ? {8'h00, vga_r, vga_g, vga_b} : 32'h0;
   assign act_one = {{(CNT_W-1){1'b0}}, vga_blank_n};

   // Frame-closing view: a coincident hs edge closes its line before the frame closes.
   logic [CNT_W-1:0] line_len_c;
   logic [CNT_W-1:0] h_act_c;
   logic [CNT_W-1:0] vcnt_c;
   logic [CNT_W-1:0] vact_c;

   always_comb begin
      line_len_c = line_len;
      h_act_c    = h_act_acc;
      vcnt_c     = vcnt;
      vact_c     = vact;
      if (hs_edge) begin
         line_len_c = hcnt;
         vcnt_c     = sat_inc(vcnt);
         if (line_act != '0) begin
            h_act_c = line_act;
            vact_c  = sat_inc(vact);
         end
      end
   end

   // The slot carrying an edge is the first slot of the new line/frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt      <= '0;
         line_act  <= '0;
         line_len  <= '0;
         h_act_acc <= '0;
         vcnt      <= '0;
         vact      <= '0;
         sum_acc   <= '0;
      end else if (pixel_en) begin
         hcnt     <= hs_edge ? CNT_W'(1) : sat_inc(hcnt);
         line_len <= line_len_c;
         if (hs_edge) begin
            line_act <= act_one;
         end else if (vga_blank_n) begin
            line_act <= sat_inc(line_act);
         end
         if (vs_edge) begin
            h_act_acc <= '0;
            vcnt      <= '0;
            vact      <= '0;
            sum_acc   <= pix_val;
         end else begin
            h_act_acc <= h_act_c;
            vcnt      <= vcnt_c;
            vact      <= vact_c;
            sum_acc   <= sum_acc + pix_val;
         end
      end
   end

   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (pixel_en) begin
         if (vs_edge) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
      end
   end

   assign timeout = pixel_en & ~vs_edge & (idle_cnt == IDLE_LAST);

   timing_t new_t;
   timing_t prev_t;
   logic    match;

   always_comb begin
      new_t           = '0;
      prev_t          = '0;
      new_t.h_total   = CNT_W_MAX'(line_len_c);
      new_t.h_active  = CNT_W_MAX'(h_act_c);
      new_t.v_total   = CNT_W_MAX'(vcnt_c);
      new_t.v_active  = CNT_W_MAX'(vact_c);
      prev_t.h_total  = CNT_W_MAX'(h_total);
      prev_t.h_active = CNT_W_MAX'(h_active);
      prev_t.v_total  = CNT_W_MAX'(v_total);
      prev_t.v_active = CNT_W_MAX'(v_active);
   end

   assign match = (new_t == prev_t);

   mon_state_t state;
   mon_state_t state_nxt;
   logic [3:0] match_cnt;
   logic [3:0] match_inc;
   logic [3:0] match_cnt_nxt;
   logic       load_frame;
   logic       lost_nxt;

   assign match_inc = (&match_cnt) ? match_cnt : match_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEARCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEARCH: begin
            if (vs_edge) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (timeout) begin
               state_nxt = SEARCH;
            end else if (vs_edge && match && (match_inc >= LOCK_N)) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (timeout) begin
               state_nxt = SEARCH;
            end else if (vs_edge && !match) begin
               state_nxt = MEASURE;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_comb begin
      load_frame    = 1'b0;
      lost_nxt      = 1'b0;
      match_cnt_nxt = match_cnt;
      case (state)
         SEARCH: begin
            if (vs_edge) match_cnt_nxt = '0;
         end
         MEASURE, LOCKED: begin
            if (timeout) begin
               match_cnt_nxt = '0;
               lost_nxt      = (state == LOCKED);
            end else if (vs_edge) begin
               load_frame    = 1'b1;
               match_cnt_nxt = match ? match_inc : 4'd0;
               lost_nxt      = (state == LOCKED) & ~match;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_total     <= '0;
         h_active    <= '0;
         v_total     <= '0;
         v_active    <= '0;
         frame_sum   <= '0;
         frame_count <= '0;
         locked      <= 1'b0;
         frame_done  <= 1'b0;
         lost        <= 1'b0;
         match_cnt   <= '0;
      end else begin
         frame_done <= load_frame;
         lost       <= lost_nxt;
         locked     <= (state_nxt == LOCKED);
         match_cnt  <= match_cnt_nxt;
         if (load_frame) begin
            h_total     <= line_len_c;
            h_active    <= h_act_c;
            v_total     <= vcnt_c;
            v_active    <= vact_c;
            frame_sum   <= sum_acc;
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor: reduced 20x10 timing, lock, lock loss, timeout, reset.
// Expected frame reports are queued at each driven vs edge and checked on frame_done.
module tb_vga_frame_monitor;

   localparam int LOCK_FRAMES = 2;
   localparam int TIMEOUT_CYC = 500;

   logic        clk = 1'b0;
   logic        reset;
   logic        pixel_en;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n;
   logic [11:0] h_total, h_active, v_total, v_active;
   logic [31:0] frame_sum;
   logic [15:0] frame_count;
   logic        locked, frame_done, lost;

   always #5 clk = ~clk;

   vga_frame_monitor #(
      .CNT_W           (12),
      .SYNC_ACTIVE_LOW (1),
      .LOCK_FRAMES     (LOCK_FRAMES),
      .TIMEOUT_CYC     (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pixel_en    (pixel_en),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .h_total     (h_total),
      .h_active    (h_active),
      .v_total     (v_total),
      .v_active    (v_active),
      .frame_sum   (frame_sum),
      .frame_count (frame_count),
      .locked      (locked),
      .frame_done  (frame_done),
      .lost        (lost)
   );

   typedef struct {
      int          h_tot;
      int          h_act;
      int          v_tot;
      int          v_act;
      logic [31:0] sum;
   } frm_t;

   typedef struct {
      frm_t        f;
      logic [15:0] cnt;
      logic        lk;
      logic        lst;
   } exp_t;

   exp_t        sb[$];
   frm_t        last_frm;
   frm_t        m_prev;
   bit          m_search;
   bit          m_locked;
   int          m_match;
   logic [15:0] m_count;
   bit          toggle_en = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          vs_cyc = -1;
   int          last_done_cyc = 0;
   int          to_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_search = 1'b1;
      m_locked = 1'b0;
      m_match  = 0;
      m_count  = '0;
      m_prev   = '{h_tot: 0, h_act: 0, v_tot: 0, v_act: 0, sum: 32'h0};
   endtask

   // Transaction-level model of one vs edge closing the frame in last_frm.
   task automatic model_vs();
      exp_t e;
      bit   same;
      if (m_search) begin
         m_search = 1'b0;
         m_match  = 0;
         return;
      end
      same = (last_frm.h_tot == m_prev.h_tot) && (last_frm.h_act == m_prev.h_act) &&
             (last_frm.v_tot == m_prev.v_tot) && (last_frm.v_act == m_prev.v_act);
      e.lst = 1'b0;
      if (same) m_match++;
      else m_match = 0;
      if (m_locked && !same) begin
         m_locked = 1'b0;
         e.lst    = 1'b1;
      end else if (!m_locked && m_match >= LOCK_FRAMES) begin
         m_locked = 1'b1;
      end
      m_count++;
      m_prev = last_frm;
      e.f    = last_frm;
      e.cnt  = m_count;
      e.lk   = m_locked;
      sb.push_back(e);
   endtask

   task automatic drive_slot(input logic hs, input logic vs, input logic bl, input logic [23:0] px);
      pixel_en    = 1'b1;
      vga_hs      = hs;
      vga_vs      = vs;
      vga_blank_n = bl;
      {vga_r, vga_g, vga_b} = px;
      @(posedge clk); #1;
      if (toggle_en) begin
         pixel_en    = 1'b0;
         vga_hs      = 1'($urandom);
         vga_vs      = 1'($urandom);
         vga_blank_n = 1'($urandom);
         {vga_r, vga_g, vga_b} = 24'($urandom);
         @(posedge clk); #1;
      end
   endtask

   // 10 lines; hs low slots 0-1, vs low lines 0-1, last 16 slots of lines 2-9 active.
   task automatic drive_frame(input int h_tot, input bit rnd_px, input logic [23:0] px_fix,
                              input int rst_line);
      frm_t        f;
      logic [23:0] px;
      logic        bl;
      f = '{h_tot: h_tot, h_act: 16, v_tot: 10, v_act: 8, sum: 32'h0};
      model_vs();
      vs_cyc = cyc + 1;
      for (int ln = 0; ln < 10; ln++) begin
         for (int s = 0; s < h_tot; s++) begin
            px = rnd_px ? 24'($urandom) : px_fix;
            bl = (ln >= 2) && (s >= h_tot - 16);
            if (bl) f.sum += {8'h00, px};
            if (ln == rst_line && s == 10) reset = 1'b1;
            drive_slot(!(s < 2), !(ln < 2), bl, px);
            if (reset) begin
               reset = 1'b0;
               model_reset();
               chk("midrst_h_total", h_total, 0);
               chk("midrst_v_total", v_total, 0);
               chk("midrst_frame_sum", frame_sum, 0);
               chk("midrst_frame_count", frame_count, 0);
               chk("midrst_locked", locked, 0);
            end
         end
      end
      last_frm = f;
   endtask

   task automatic drive_novs(input int lines);
      for (int ln = 0; ln < lines; ln++) begin
         for (int s = 0; s < 20; s++) begin
            drive_slot(!(s < 2), 1'b1, 1'b0, 24'h0);
         end
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         if (frame_done) begin
            if (sb.size() == 0) begin
               chk("done_expected", frame_done, 0);
            end else begin
               e = sb.pop_front();
               chk("h_total", h_total, e.f.h_tot);
               chk("h_active", h_active, e.f.h_act);
               chk("v_total", v_total, e.f.v_tot);
               chk("v_active", v_active, e.f.v_act);
               chk("frame_sum", frame_sum, e.f.sum);
               chk("frame_count", frame_count, e.cnt);
               chk("locked", locked, e.lk);
               chk("lost", lost, e.lst);
               chk("done_latency", cyc, vs_cyc);
            end
            last_done_cyc = cyc;
         end else if (lost) begin
            to_seen++;
            chk("timeout_slots", cyc - last_done_cyc, TIMEOUT_CYC);
            chk("timeout_unlock", locked, 0);
            chk("timeout_hold_h_total", h_total, 20);
            chk("timeout_hold_count", frame_count, m_count);
         end
      end
   end

   initial begin
      reset       = 1'b1;
      pixel_en    = 1'b0;
      vga_hs      = 1'b1;
      vga_vs      = 1'b1;
      vga_blank_n = 1'b0;
      {vga_r, vga_g, vga_b} = 24'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_h_total", h_total, 0);
      chk("rst_h_active", h_active, 0);
      chk("rst_v_total", v_total, 0);
      chk("rst_v_active", v_active, 0);
      chk("rst_frame_sum", frame_sum, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_locked", locked, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_lost", lost, 0);
      reset = 1'b0;

      repeat (4) drive_frame(20, 1'b0, 24'h000001, -1);
      chk("locked_after_3_reports", locked, 1);

      toggle_en = 1'b1;
      repeat (3) drive_frame(20, 1'b1, 24'h0, -1);
      toggle_en = 1'b0;

      drive_frame(21, 1'b1, 24'h0, -1);
      repeat (4) drive_frame(20, 1'b1, 24'h0, -1);
      chk("relocked", locked, 1);

      to_seen = 0;
      drive_novs(30);
      m_search = 1'b1;
      m_locked = 1'b0;
      chk("timeout_seen", to_seen, 1);

      drive_frame(20, 1'b0, 24'h000000, 5);
      repeat (4) drive_frame(20, 1'b0, 24'hFFFFFF, -1);

      pixel_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      chk("final_frame_count", frame_count, 3);
      chk("final_frame_sum", frame_sum, 32'h7FFFFF80);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
